uart_frame_decoder: RTL and testbench

- Receive-side counterpart of the tank-state UART transmitter.
- Consumes bytes from the UART receiver (one strobe per byte), finds the 4×0xFF sync preamble, and collects the 10-byte payload into shadow registers.
- Validates the payload and commits it atomically to the enemy-tank state outputs used by the game/render logic.
- Handles mid-stream join, inter-byte timeout and malformed frames by resynchronising.

---
 rtl/uart_frame_decoder_if.sv | 11 +
 rtl/uart_frame_decoder.sv | 198 +++++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_frame_decoder_if.sv
// Byte stream from the UART receiver into the tank-state frame decoder.
//   rx_data : received byte, valid while rx_done is high
//   rx_done : one-cycle strobe per received byte
// master = UART receiver side (drives the byte), slave = decoder side.
interface uart_frame_decoder_if;
  logic [7:0] rx_data;
  logic       rx_done;

  modport master (output rx_data, rx_done);
  modport slave  (input  rx_data, rx_done);
endinterface

// File: rtl/uart_frame_decoder.sv
// Receive-side decoder for the tank-state UART link.
// Hunts for a run of SYNC_COUNT x SYNC_BYTE, collects the 10-byte payload
// (XL XH YL YH BXL BXH BYL BYH HP FLAGS) into a shadow copy, validates it
// byte by byte and commits it to the enemy-tank outputs in a single cycle.
// Malformed bytes and inter-byte stalls longer than TIMEOUT abandon the frame.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   rx                   : byte stream from the UART receiver (slave side)
//   xpos/ypos_enemy      : enemy tank position
//   x/ypos_bullet_enemy  : enemy bullet position
//   HP_our_state         : our HP as seen by the peer
//   direction_enemy, tank_enemy_hit, obstacle_hit_enemy, direction_tank_enemy
//                        : FLAGS byte fields
//   frame_valid          : one-cycle pulse when a frame is committed
//   frame_err_cnt        : saturating count of rejected frames
module uart_frame_decoder #(
  parameter logic [7:0] SYNC_BYTE  = 8'hFF,
  parameter int         SYNC_COUNT = 4,      // must be >= 2
  parameter int         TIMEOUT    = 40000
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_frame_decoder_if.slave  rx,
  output logic [9:0]           xpos_enemy,
  output logic [9:0]           ypos_enemy,
  output logic [9:0]           xpos_bullet_enemy,
  output logic [9:0]           ypos_bullet_enemy,
  output logic [7:0]           HP_our_state,
  output logic [2:0]           direction_enemy,
  output logic                 tank_enemy_hit,
  output logic                 obstacle_hit_enemy,
  output logic [1:0]           direction_tank_enemy,
  output logic                 frame_valid,
  output logic [7:0]           frame_err_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(SYNC_COUNT + 1);

  typedef enum logic [1:0] {HUNT, SYNC, DATA, COMMIT} state_t;

  // Only the bits that reach the outputs are kept; the rest of each byte
  // is either checked on arrival (H bytes, FLAGS bit7) or unused.
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] bx;
    logic [9:0] by;
    logic [7:0] hp;
    logic [6:0] flags;
  } payload_t;

  state_t          state;
  logic [CW-1:0]   sync_cnt;
  logic [3:0]      idx;
  logic [TW-1:0]   timer;
  payload_t        shadow;

  logic is_sync;
  logic byte_ok;
  logic timed_out;

  // NOTE: every signal written here gets a value before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    is_sync   = (rx.rx_data == SYNC_BYTE);
    // A byte arriving on the last allowed cycle wins over the timeout.
    timed_out = !rx.rx_done && (timer == TW'(TIMEOUT));
    byte_ok   = 1'b1;
    case (idx)
      4'd1, 4'd3, 4'd5, 4'd7: byte_ok = (rx.rx_data <= 8'h03);
      4'd9:                   byte_ok = !rx.rx_data[7];
      default:                byte_ok = 1'b1;
    endcase
  end

  // NOTE: the shadow copy has no reset. It only reaches the outputs after
  // all ten bytes of a fresh frame have overwritten it, so stale contents
  // can never leak out.
  always_ff @(posedge clk) begin
    if (state == DATA && rx.rx_done) begin
      case (idx)
        4'd0:    shadow.x[7:0]  <= rx.rx_data;
        4'd1:    shadow.x[9:8]  <= rx.rx_data[1:0];
        4'd2:    shadow.y[7:0]  <= rx.rx_data;
        4'd3:    shadow.y[9:8]  <= rx.rx_data[1:0];
        4'd4:    shadow.bx[7:0] <= rx.rx_data;
        4'd5:    shadow.bx[9:8] <= rx.rx_data[1:0];
        4'd6:    shadow.by[7:0] <= rx.rx_data;
        4'd7:    shadow.by[9:8] <= rx.rx_data[1:0];
        4'd8:    shadow.hp      <= rx.rx_data;
        4'd9:    shadow.flags   <= rx.rx_data[6:0];
        default: ;
      endcase
    end
  end

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= HUNT;
      sync_cnt             <= '0;
      idx                  <= '0;
      timer                <= '0;
      xpos_enemy           <= '0;
      ypos_enemy           <= '0;
      xpos_bullet_enemy    <= '0;
      ypos_bullet_enemy    <= '0;
      HP_our_state         <= '0;
      direction_enemy      <= '0;
      tank_enemy_hit       <= 1'b0;
      obstacle_hit_enemy   <= 1'b0;
      direction_tank_enemy <= '0;
      frame_valid          <= 1'b0;
      frame_err_cnt        <= '0;
    end else begin
      frame_valid <= 1'b0;

      // Timer measures the gap since the last byte while a frame is open.
      if (rx.rx_done || state == HUNT || state == COMMIT || timed_out)
        timer <= '0;
      else
        timer <= timer + 1'b1;

      case (state)
        HUNT, COMMIT: begin
          if (state == COMMIT) begin
            xpos_enemy           <= shadow.x;
            ypos_enemy           <= shadow.y;
            xpos_bullet_enemy    <= shadow.bx;
            ypos_bullet_enemy    <= shadow.by;
            HP_our_state         <= shadow.hp;
            obstacle_hit_enemy   <= shadow.flags[6];
            direction_tank_enemy <= shadow.flags[5:4];
            direction_enemy      <= shadow.flags[3:1];
            tank_enemy_hit       <= shadow.flags[0];
            frame_valid          <= 1'b1;
          end
          // The commit cycle also listens for the next preamble, so a
          // back-to-back frame is not lost.
          state <= HUNT;
          if (rx.rx_done && is_sync) begin
            state    <= SYNC;
            sync_cnt <= CW'(1);
          end
        end

        SYNC: begin
          if (rx.rx_done) begin
            if (!is_sync) begin
              state    <= HUNT;
              sync_cnt <= '0;
            end else if (sync_cnt == CW'(SYNC_COUNT - 1)) begin
              state    <= DATA;
              idx      <= '0;
              sync_cnt <= '0;
            end else begin
              sync_cnt <= sync_cnt + 1'b1;
            end
          end else if (timed_out) begin
            state    <= HUNT;
            sync_cnt <= '0;
          end
        end

        DATA: begin
          if (rx.rx_done) begin
            if (!byte_ok) begin
              frame_err_cnt <= sat_inc(frame_err_cnt);
              // A rejected SYNC_BYTE may be the start of the next preamble.
              if (is_sync) begin
                state    <= SYNC;
                sync_cnt <= CW'(1);
              end else begin
                state <= HUNT;
              end
            end else if (idx == 4'd9) begin
              state <= COMMIT;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (timed_out) begin
            state         <= HUNT;
            frame_err_cnt <= sat_inc(frame_err_cnt);
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed self-checking bench for uart_frame_decoder.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_uart_frame_decoder;

  localparam int TO = 64;

  // Payloads, XL first in the top byte.
  localparam logic [79:0] F1   = 80'h2C01_F000_0502_1003_645B;
  localparam logic [79:0] F2   = 80'hFF01_F000_0502_1003_FF26;
  localparam logic [79:0] FJ   = 80'hFF01_F000_0502_1003_645B;
  localparam logic [79:0] FBAD = 80'h2C01_F000_0502_1003_6480;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_decoder_if bus ();

  logic [9:0] xpos_enemy, ypos_enemy, xpos_bullet_enemy, ypos_bullet_enemy;
  logic [7:0] HP_our_state;
  logic [2:0] direction_enemy;
  logic       tank_enemy_hit, obstacle_hit_enemy;
  logic [1:0] direction_tank_enemy;
  logic       frame_valid;
  logic [7:0] frame_err_cnt;

  uart_frame_decoder #(.SYNC_BYTE(8'hFF), .SYNC_COUNT(4), .TIMEOUT(TO)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rx                   (bus),
    .xpos_enemy           (xpos_enemy),
    .ypos_enemy           (ypos_enemy),
    .xpos_bullet_enemy    (xpos_bullet_enemy),
    .ypos_bullet_enemy    (ypos_bullet_enemy),
    .HP_our_state         (HP_our_state),
    .direction_enemy      (direction_enemy),
    .tank_enemy_hit       (tank_enemy_hit),
    .obstacle_hit_enemy   (obstacle_hit_enemy),
    .direction_tank_enemy (direction_tank_enemy),
    .frame_valid          (frame_valid),
    .frame_err_cnt        (frame_err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int exp_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b, input int gap);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic preamble(input int gap);
    repeat (4) strobe(8'hFF, gap);
  endtask

  // Bytes first..last of a payload; no idle gap after the FLAGS byte.
  task automatic payload(input logic [79:0] pl, input int first, input int last, input int gap);
    for (int i = first; i <= last; i++)
      strobe(pl[79-8*i -: 8], (i == 9) ? 0 : gap);
  endtask

  task automatic send_frame(input logic [79:0] pl, input int gap);
    preamble(gap);
    payload(pl, 0, 9, gap);
  endtask

  task automatic expect_outs(input string tag, input int x, input int y, input int bx,
                             input int by, input int hp, input int dir, input int hit,
                             input int obs, input int dt);
    check({tag, ".x"},    32'(xpos_enemy),           x);
    check({tag, ".y"},    32'(ypos_enemy),           y);
    check({tag, ".bx"},   32'(xpos_bullet_enemy),    bx);
    check({tag, ".by"},   32'(ypos_bullet_enemy),    by);
    check({tag, ".hp"},   32'(HP_our_state),         hp);
    check({tag, ".dir"},  32'(direction_enemy),      dir);
    check({tag, ".hit"},  32'(tank_enemy_hit),       hit);
    check({tag, ".obs"},  32'(obstacle_hit_enemy),   obs);
    check({tag, ".dt"},   32'(direction_tank_enemy), dt);
  endtask

  // Called right after the FLAGS strobe: pulse must appear one cycle later.
  task automatic expect_commit(input string tag, input int x, input int y, input int bx,
                               input int by, input int hp, input int dir, input int hit,
                               input int obs, input int dt);
    check({tag, ".fv_early"}, 32'(frame_valid), 0);
    @(negedge clk);
    check({tag, ".fv"}, 32'(frame_valid), 1);
    expect_outs(tag, x, y, bx, by, hp, dir, hit, obs, dt);
    @(negedge clk);
    check({tag, ".fv_end"}, 32'(frame_valid), 0);
  endtask

  task automatic expect_no_commit(input string tag);
    repeat (3) begin
      check({tag, ".fv_none"}, 32'(frame_valid), 0);
      @(negedge clk);
    end
  endtask

  task automatic check_err(input string tag);
    check({tag, ".err"}, 32'(frame_err_cnt), 32'(exp_err));
  endtask

  initial begin
    rst         = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_done = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    expect_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("reset.fv", 32'(frame_valid), 0);
    check_err("reset");
    rst = 1'b1;
    @(negedge clk);

    // Reference frame
    send_frame(F1, 1);
    expect_commit("f1", 300, 240, 517, 784, 100, 5, 1, 1, 1);
    check_err("f1");

    // 0xFF inside the payload is data, not preamble
    send_frame(F2, 1);
    expect_commit("f2", 511, 240, 517, 784, 255, 3, 0, 0, 2);

    // Back-to-back frames: the second preamble starts during COMMIT
    send_frame(F1, 0);
    send_frame(F2, 0);
    expect_commit("b2b", 511, 240, 517, 784, 255, 3, 0, 0, 2);

    // Mid-stream join: 3 FF + XL=FF -> misaligned, YL=F0 lands on an H slot
    repeat (3) strobe(8'hFF, 1);
    payload(FJ, 0, 9, 1);
    expect_no_commit("join");
    exp_err = 1;
    check_err("join");
    expect_outs("join.hold", 511, 240, 517, 784, 255, 3, 0, 0, 2);
    send_frame(F1, 1);
    expect_commit("join.next", 300, 240, 517, 784, 100, 5, 1, 1, 1);

    // Rejected byte equal to SYNC_BYTE counts as the first preamble byte
    preamble(1);
    strobe(8'h11, 1);
    strobe(8'hFF, 1);
    exp_err = 2;
    check_err("ffrej");
    repeat (3) strobe(8'hFF, 1);
    payload(F2, 0, 9, 1);
    expect_commit("ffrej.next", 511, 240, 517, 784, 255, 3, 0, 0, 2);
    check_err("ffrej.next");

    // Byte arriving exactly when timer == TIMEOUT is still accepted
    preamble(1);
    payload(F1, 0, 2, 1);
    strobe(8'h00, TO);
    payload(F1, 4, 9, 1);
    expect_commit("to_edge", 300, 240, 517, 784, 100, 5, 1, 1, 1);
    check_err("to_edge");

    // Stall inside DATA longer than TIMEOUT
    preamble(1);
    payload(F2, 0, 4, 1);
    repeat (TO + 4) @(negedge clk);
    exp_err = 3;
    check_err("to_data");
    expect_no_commit("to_data");
    expect_outs("to_data.hold", 300, 240, 517, 784, 100, 5, 1, 1, 1);
    send_frame(F2, 1);
    expect_commit("to_data.next", 511, 240, 517, 784, 255, 3, 0, 0, 2);

    // Stall inside SYNC: preamble restarts, no error counted
    strobe(8'hFF, 1);
    strobe(8'hFF, TO + 4);
    strobe(8'hFF, 1);
    strobe(8'hFF, 1);
    payload(F1, 0, 9, 1);
    expect_no_commit("to_sync");
    check_err("to_sync");
    expect_outs("to_sync.hold", 511, 240, 517, 784, 255, 3, 0, 0, 2);

    // FLAGS bit7 set
    send_frame(FBAD, 1);
    expect_no_commit("flags80");
    exp_err = 4;
    check_err("flags80");

    // Error counter saturation: 251 more reaches 255, 9 more stay there
    repeat (251) begin
      preamble(0);
      strobe(8'h00, 0);
      strobe(8'h04, 0);
    end
    exp_err = 255;
    check_err("sat255");
    repeat (9) begin
      preamble(0);
      strobe(8'h00, 0);
      strobe(8'h04, 0);
    end
    check_err("sat_hold");
    expect_outs("sat.hold", 511, 240, 517, 784, 255, 3, 0, 0, 2);

    // Asynchronous reset during byte 7
    preamble(1);
    payload(F1, 0, 6, 1);
    bus.rx_data = 8'h03;
    bus.rx_done = 1'b1;
    #2 rst = 1'b0;
    #1;
    expect_outs("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_mid.fv", 32'(frame_valid), 0);
    exp_err = 0;
    check_err("rst_mid");
    bus.rx_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    send_frame(F1, 1);
    expect_commit("rst_next", 300, 240, 517, 784, 100, 5, 1, 1, 1);
    check_err("rst_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
